// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Bus between the control unit and the PC/timing sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W+3:0] IN_IR;
  logic [ADDR_W-1:0] IN_AR;
  logic              AC_MSB;
  logic              AC_ZERO;
  logic              E_BIT;
  logic              DR_ZERO;
  logic              FGI;
  logic              FGO;
  logic [ADDR_W-1:0] Q_PC;
  logic [7:0]        T;
  logic [7:0]        D;
  logic              R_FLAG;
  logic              IEN;
  logic              HALTED;
  logic              SKIP;

  modport master (
    output IN_IR, IN_AR, AC_MSB, AC_ZERO, E_BIT, DR_ZERO, FGI, FGO,
    input  Q_PC, T, D, R_FLAG, IEN, HALTED, SKIP
  );

  modport slave (
    input  IN_IR, IN_AR, AC_MSB, AC_ZERO, E_BIT, DR_ZERO, FGI, FGO,
    output Q_PC, T, D, R_FLAG, IEN, HALTED, SKIP
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter, T0..T7 sequence counter, opcode decode and
//               interrupt flip-flops for the basic computer.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int              ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] INT_VEC   = '0
) (
  input  logic           CLK,
  input  logic           RST,
  pc_sequencer_if.slave  bus
);

  logic [2:0]        r_sc;
  logic [ADDR_W-1:0] r_pc;
  logic              r_r;
  logic              r_ien;
  logic              r_halted;
  logic              r_skip;

  logic              w_i;
  logic [2:0]        w_op;
  logic [7:0]        w_t;
  logic [7:0]        w_d;
  logic              w_r;
  logic              w_p;
  logic              w_fetch_inc;
  logic              w_ld;
  logic              w_skip;
  logic              w_clr_sc;
  logic              w_set_r;
  logic              w_r_done;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_unused_ir;

  assign w_i  = bus.IN_IR[ADDR_W+3];
  assign w_op = bus.IN_IR[ADDR_W+2:ADDR_W];
  assign w_t  = 8'b1 << r_sc;
  assign w_d  = 8'b1 << w_op;

  assign w_r = w_d[7] & ~w_i & w_t[3];
  assign w_p = w_d[7] &  w_i & w_t[3];

  // B fields not acted on by this unit
  assign w_unused_ir = ^{bus.IN_IR[ADDR_W-1:10], bus.IN_IR[5]};

  assign w_fetch_inc = ~r_r & w_t[1];
  assign w_ld        = ~r_r & ((w_d[4] & w_t[4]) | (w_d[5] & w_t[5]));
  assign w_r_done    = r_r & w_t[2];

  // Any number of true conditions still yields a single increment
  assign w_skip = ~r_r & ((w_d[6] & w_t[6] & bus.DR_ZERO)
                | (w_r & ((bus.IN_IR[4] & ~bus.AC_MSB) | (bus.IN_IR[3] & bus.AC_MSB)
                        | (bus.IN_IR[2] & bus.AC_ZERO) | (bus.IN_IR[1] & ~bus.E_BIT)))
                | (w_p & ((bus.IN_IR[9] & bus.FGI) | (bus.IN_IR[8] & bus.FGO))));

  assign w_clr_sc = w_r_done
                  | (~r_r & ((w_t[5] & (w_d[0] | w_d[1] | w_d[2] | w_d[5]))
                           | (w_t[4] & (w_d[3] | w_d[4]))
                           | (w_t[6] & w_d[6])
                           | w_r | w_p));

  // Uses the pre-edge IEN, so an ION in this T3 cannot set R yet
  assign w_set_r = ~r_r & (r_sc >= 3'd3) & r_ien & (bus.FGI | bus.FGO);

  always_comb begin
    w_pc_nxt = r_pc;
    if (r_r & w_t[1])
      w_pc_nxt = INT_VEC;
    else if (w_r_done)
      w_pc_nxt = r_pc + ADDR_W'(1);
    else if (w_ld)
      w_pc_nxt = bus.IN_AR;
    else if (w_fetch_inc | w_skip)
      w_pc_nxt = r_pc + ADDR_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sc     <= 3'd0;
      r_pc     <= RESET_VEC;
      r_r      <= 1'b0;
      r_ien    <= 1'b0;
      r_halted <= 1'b0;
      r_skip   <= 1'b0;
    end else if (!r_halted) begin
      r_sc     <= w_clr_sc ? 3'd0 : r_sc + 3'd1;
      r_pc     <= w_pc_nxt;
      r_halted <= w_r & bus.IN_IR[0];
      r_skip   <= w_skip;
      if (w_r_done)
        r_r <= 1'b0;
      else if (w_set_r)
        r_r <= 1'b1;
      // IOF wins when ION and IOF are issued together
      if (w_r_done || (w_p && bus.IN_IR[6]))
        r_ien <= 1'b0;
      else if (w_p && bus.IN_IR[7])
        r_ien <= 1'b1;
    end else begin
      r_skip <= 1'b0;
    end
  end

  assign bus.Q_PC   = r_pc;
  assign bus.T      = w_t;
  assign bus.D      = w_d;
  assign bus.R_FLAG = r_r;
  assign bus.IEN    = r_ien;
  assign bus.HALTED = r_halted;
  assign bus.SKIP   = r_skip;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic CLK;
  logic RST;
  int   n_chk;
  int   n_err;

  pc_sequencer_if #(.ADDR_W(12)) bus ();

  pc_sequencer #(
    .ADDR_W   (12),
    .RESET_VEC(12'h000),
    .INT_VEC  (12'h000)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs the current instruction until SC is back at T0
  task automatic run_to_t0(input string tag);
    step();
    for (int k = 0; k < 16 && bus.T != 8'h01; k++) step();
    check(tag, {24'd0, bus.T}, 32'h01);
  endtask

  task automatic set_pc(input logic [11:0] addr);
    bus.IN_IR = {4'h4, addr};
    bus.IN_AR = addr;
    run_to_t0("bun_t0");
    check("bun_pc", {20'd0, bus.Q_PC}, {20'd0, addr});
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    RST = 1'b1;
    bus.IN_IR = 16'h7800; bus.IN_AR = '0;
    bus.AC_MSB = 0; bus.AC_ZERO = 0; bus.E_BIT = 0; bus.DR_ZERO = 0;
    bus.FGI = 0; bus.FGO = 0;
    step(); step();

    check("rst_pc",   {20'd0, bus.Q_PC}, 32'h000);
    check("rst_t",    {24'd0, bus.T},    32'h01);
    check("rst_r",    {31'd0, bus.R_FLAG}, 0);
    check("rst_ien",  {31'd0, bus.IEN},    0);
    check("rst_halt", {31'd0, bus.HALTED}, 0);
    check("rst_skip", {31'd0, bus.SKIP},   0);
    check("d_cla",    {24'd0, bus.D},    32'h80);

    // CLA
    RST = 1'b0;
    step();
    check("cla_t1",  {24'd0, bus.T},    32'h02);
    check("cla_pc0", {20'd0, bus.Q_PC}, 32'h000);
    step();
    check("cla_pc1", {20'd0, bus.Q_PC}, 32'h001);
    step();
    check("cla_t3",  {24'd0, bus.T},    32'h08);
    step();
    check("cla_t0",  {24'd0, bus.T},    32'h01);
    check("cla_skip",{31'd0, bus.SKIP}, 0);
    for (int n = 0; n < 4; n++) run_to_t0("cla_loop");
    check("cla_pc5", {20'd0, bus.Q_PC}, 32'h005);

    // BUN
    bus.IN_IR = 16'h4123; bus.IN_AR = 12'h123;
    #1;
    check("d_bun", {24'd0, bus.D}, 32'h10);
    step(); step();
    check("bun_t1", {20'd0, bus.Q_PC}, 32'h006);
    step(); step(); step();
    check("bun_ld", {20'd0, bus.Q_PC}, 32'h123);
    check("bun_t",  {24'd0, bus.T},    32'h01);

    // SZA taken
    set_pc(12'h010);
    bus.IN_IR = 16'h7004; bus.AC_ZERO = 1'b1;
    step(); step();
    check("sza_t1",   {20'd0, bus.Q_PC}, 32'h011);
    step(); step();
    check("sza_pc",   {20'd0, bus.Q_PC}, 32'h012);
    check("sza_skip", {31'd0, bus.SKIP}, 1);
    bus.AC_ZERO = 1'b0;
    bus.IN_IR = 16'h4010; bus.IN_AR = 12'h010;
    step();
    check("sza_skip_end", {31'd0, bus.SKIP}, 0);
    run_to_t0("bun_t0");

    // SZA not taken
    bus.IN_IR = 16'h7004;
    step(); step(); step(); step();
    check("sza_no_pc",   {20'd0, bus.Q_PC}, 32'h011);
    check("sza_no_skip", {31'd0, bus.SKIP}, 0);

    // ISZ with PC wrap
    set_pc(12'hFFF);
    bus.IN_IR = 16'h6FFF; bus.DR_ZERO = 1'b1;
    step(); step();
    check("isz_wrap", {20'd0, bus.Q_PC}, 32'h000);
    for (int n = 0; n < 5; n++) step();
    check("isz_pc",   {20'd0, bus.Q_PC}, 32'h001);
    check("isz_t",    {24'd0, bus.T},    32'h01);
    check("isz_skip", {31'd0, bus.SKIP}, 1);
    bus.DR_ZERO = 1'b0;

    // ION then interrupt
    bus.IN_IR = 16'hF080;
    run_to_t0("ion_t0");
    check("ion_ien", {31'd0, bus.IEN},    1);
    check("ion_r",   {31'd0, bus.R_FLAG}, 0);
    bus.IN_IR = 16'h7800; bus.FGI = 1'b1;
    step(); step(); step(); step();
    check("int_r",  {31'd0, bus.R_FLAG}, 1);
    check("int_pc", {20'd0, bus.Q_PC},   32'h003);
    bus.FGI = 1'b0;
    step(); step();
    check("int_vec", {20'd0, bus.Q_PC}, 32'h000);
    step();
    check("int_ret_pc", {20'd0, bus.Q_PC},   32'h001);
    check("int_ien",    {31'd0, bus.IEN},    0);
    check("int_r_clr",  {31'd0, bus.R_FLAG}, 0);
    check("int_t",      {24'd0, bus.T},      32'h01);

    // ION together with IOF leaves IEN clear
    bus.IN_IR = 16'hF080;
    run_to_t0("ion2_t0");
    check("ion2_ien", {31'd0, bus.IEN}, 1);
    bus.IN_IR = 16'hF0C0;
    run_to_t0("ionf_t0");
    check("ionf_ien", {31'd0, bus.IEN}, 0);
    check("ionf_pc",  {20'd0, bus.Q_PC}, 32'h003);

    // BSA loads at T5, not T4
    bus.IN_IR = 16'h5040; bus.IN_AR = 12'h041;
    step(); step(); step(); step();
    check("bsa_t4_pc", {20'd0, bus.Q_PC}, 32'h004);
    step();
    check("bsa_t5",    {24'd0, bus.T},    32'h20);
    step();
    check("bsa_pc",    {20'd0, bus.Q_PC}, 32'h041);
    check("bsa_t0",    {24'd0, bus.T},    32'h01);

    // HLT
    set_pc(12'h020);
    bus.IN_IR = 16'h7001;
    step(); step(); step(); step();
    check("hlt_flag", {31'd0, bus.HALTED}, 1);
    check("hlt_pc",   {20'd0, bus.Q_PC},   32'h021);
    for (int n = 0; n < 20; n++) step();
    check("hlt_frozen_pc", {20'd0, bus.Q_PC}, 32'h021);
    check("hlt_frozen_t",  {24'd0, bus.T},    32'h01);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("hlt_rst_pc",   {20'd0, bus.Q_PC},   32'h000);
    check("hlt_rst_halt", {31'd0, bus.HALTED}, 0);
    check("hlt_rst_t",    {24'd0, bus.T},      32'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
